seven_seg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It takes packed hex nibbles plus per-digit decimal-point and blank controls and scans one digit per slot. A guard interval at the start of each slot suppresses ghosting. A shadow register prevents tearing. It sits between the datapath's display registers and the board's segment/anode pins.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seven_seg_scan.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment codes and sizing helper for seven_seg_scan
package seven_seg_pkg;

  // Active-low segment codes, bit0=a .. bit6=g, bit7=dp (off)
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_DP_BIT = 7;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF[6:0];
    case (hex)
      4'h0: seg = SEG_0[6:0];
      4'h1: seg = SEG_1[6:0];
      4'h2: seg = SEG_2[6:0];
      4'h3: seg = SEG_3[6:0];
      4'h4: seg = SEG_4[6:0];
      4'h5: seg = SEG_5[6:0];
      4'h6: seg = SEG_6[6:0];
      4'h7: seg = SEG_7[6:0];
      4'h8: seg = SEG_8[6:0];
      4'h9: seg = SEG_9[6:0];
      4'hA: seg = SEG_A[6:0];
      4'hB: seg = SEG_B[6:0];
      4'hC: seg = SEG_C[6:0];
      4'hD: seg = SEG_D[6:0];
      4'hE: seg = SEG_E[6:0];
      4'hF: seg = SEG_F[6:0];
      default: seg = SEG_OFF[6:0];
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed N-digit common-anode seven-segment scanner
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = clog2_min1(SCAN_DIV);
  localparam int IW = clog2_min1(NUM_DIGITS);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    tick;
  logic                    last_digit;
  logic                    in_guard;
  logic [3:0]              digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              seg7;
  logic [7:0]              seg_lit;

  assign tick       = (cnt == CW'(SCAN_DIV - 1));
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));
  assign in_guard   = (int'(cnt) < GUARD_CYC);

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k goes dark when it and every nibble above it are zero; digit 0 always shows
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (sh_value[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_above & ~sh_dp[k];
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    digit     = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        digit     = sh_value[4*k +: 4];
        cur_dp    = sh_dp[k];
        cur_blank = sh_blank[k] | lz_blank[k];
      end
    end
  end

  hex_to_seg7 u_dec (
    .hex (digit),
    .seg (seg7)
  );

  always_comb begin
    seg_lit             = SEG_OFF;
    seg_lit[6:0]        = seg7;
    seg_lit[SEG_DP_BIT] = ~cur_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      seg      <= SEG_OFF;
      an       <= '1;
    end else if (!en) begin
      // While idle the shadow tracks the inputs so enabling starts from fresh data
      cnt      <= '0;
      idx      <= '0;
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blank <= blank_in;
      seg      <= SEG_OFF;
      an       <= '1;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= last_digit ? '0 : idx + 1'b1;
        if (last_digit) begin
          sh_value <= value;
          sh_dp    <= dp_in;
          sh_blank <= blank_in;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (in_guard || cur_blank) begin
        seg <= SEG_OFF;
        an  <= '1;
      end else begin
        seg <= seg_lit;
        an  <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan (honours LEADING_ZERO_BLANK_EN)
module tb_seven_seg_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [7:0]  seg;
  logic [3:0]  an;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  seven_seg_scan #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .GUARD_CYC  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .value    (value),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [3:0] ea, input logic [7:0] es);
    n_tests++;
    if (an !== ea || seg !== es) begin
      n_fail++;
      $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", name, an, seg, ea, es);
    end
  endfunction

  // Monitor: every output cycle is sampled on the falling edge against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check(e.name, e.an, e.seg);
      end
    end
  end

  task automatic cyc(input string name, input logic [3:0] ea, input logic [7:0] es);
    exp_t e;
    @(posedge clk);
    e.name = name;
    e.an   = ea;
    e.seg  = es;
    q.push_back(e);
    #1;
  endtask

  task automatic do_slot(input string name, input int k, input logic [7:0] s, input bit lit);
    logic [3:0] a;
    a = ~(4'(1) << k);
    cyc({name, "_guard"}, 4'hF, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      if (lit) cyc(name, a, s);
      else     cyc(name, 4'hF, 8'hFF);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; value = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
    cyc("reset", 4'hF, 8'hFF);
    cyc("reset", 4'hF, 8'hFF);
    rst_n = 1'b1;
    cyc("idle", 4'hF, 8'hFF);
    cyc("idle", 4'hF, 8'hFF);
    en = 1'b1;

    // Frame 1: value 1234
    do_slot("f1_d0", 0, 8'h99, 1);
    do_slot("f1_d1", 1, 8'hB0, 1);
    do_slot("f1_d2", 2, 8'hA4, 1);
    do_slot("f1_d3", 3, 8'hF9, 1);

    // Frame 2: input changes mid-frame must not tear
    do_slot("f2_d0", 0, 8'h99, 1);
    do_slot("f2_d1", 1, 8'hB0, 1);
    value = 16'hABCD;
    do_slot("tear_d2", 2, 8'hA4, 1);
    do_slot("tear_d3", 3, 8'hF9, 1);

    // Frame 3: ABCD, while loading dp/blank controls for the next frame
    do_slot("f3_d0", 0, 8'hA1, 1);
    value = 16'h1234; dp_in = 4'b0100; blank_in = 4'b0001;
    do_slot("f3_d1", 1, 8'hC6, 1);
    do_slot("f3_d2", 2, 8'h83, 1);
    do_slot("f3_d3", 3, 8'h88, 1);

    // Frame 4: digit 0 blanked, dp on digit 2
    do_slot("blank_d0", 0, 8'hFF, 0);
    do_slot("f4_d1", 1, 8'hB0, 1);
    do_slot("dp_d2", 2, 8'h24, 1);
    dp_in = 4'h0; blank_in = 4'h0;
    do_slot("f4_d3", 3, 8'hF9, 1);

    // Frame 5: drop enable mid-slot, then restart with a fresh shadow
    cyc("f5_guard", 4'hF, 8'hFF);
    cyc("f5_d0", 4'hE, 8'h99);
    en = 1'b0;
    cyc("en_off", 4'hF, 8'hFF);
    value = 16'h5678;
    cyc("en_off_hold", 4'hF, 8'hFF);
    en = 1'b1;
    do_slot("re_d0", 0, 8'h80, 1);
    value = 16'h0047;
    do_slot("re_d1", 1, 8'hF8, 1);
    do_slot("re_d2", 2, 8'h82, 1);
    do_slot("re_d3", 3, 8'h92, 1);

    // Leading-zero frames: 0047 then 0000
    do_slot("lz47_d0", 0, 8'hF8, 1);
    value = 16'h0000;
    do_slot("lz47_d1", 1, 8'h99, 1);
    do_slot("lz47_d2", 2, 8'hC0, !LZ);
    do_slot("lz47_d3", 3, 8'hC0, !LZ);
    do_slot("lz0_d0", 0, 8'hC0, 1);
    do_slot("lz0_d1", 1, 8'hC0, !LZ);
    do_slot("lz0_d2", 2, 8'hC0, !LZ);
    do_slot("lz0_d3", 3, 8'hC0, !LZ);

    // Asynchronous reset asserted mid-slot while a digit is lit
    value = 16'h1234;
    cyc("pre_rst_guard", 4'hF, 8'hFF);
    cyc("pre_rst_lit", 4'hE, 8'hC0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", 4'hF, 8'hFF);
    cyc("rst_hold", 4'hF, 8'hFF);
    rst_n = 1'b1;
    // Shadow was cleared: digit 0 shows 0 after a full guard slot
    do_slot("post_rst_d0", 0, 8'hC0, 1);

    stim_done = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
